// File: rtl/fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx
//
// Drains bytes from an upstream registered-read byte FIFO and serialises each
// one as an 8N1 UART frame (start bit, 8 data bits LSB first, one stop bit).
// The line idles high.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per UART bit period (2..65535)
//
// Ports
//   clk_i          sole clock, rising edge
//   rst_ni         asynchronous active-low reset
//   en_i           drain enable; low stops new fetches, never aborts a frame
//   empty_i        upstream FIFO empty flag
//   rdata_i[7:0]   upstream FIFO read data, valid the cycle after re_o
//   re_o           FIFO read strobe, one single-cycle pulse per byte
//   tx_o           UART serial output
//   busy_o         high whenever the FSM is not in IDLE
//   byte_done_o    single-cycle pulse in the last cycle of each stop bit
// -----------------------------------------------------------------------------
module fifo_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       en_i,
    input  logic       empty_i,
    input  logic [7:0] rdata_i,
    output logic       re_o,
    output logic       tx_o,
    output logic       busy_o,
    output logic       byte_done_o
);

    // Counter only ever has to hold CLKS_PER_BIT-1.
    localparam int unsigned CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        LOAD  = 3'd2,
        START = 3'd3,
        DATA  = 3'd4,
        STOP  = 3'd5
    } state_e;

    state_e           state_q,  state_d;
    logic [7:0]       shift_q,  shift_d;
    logic [2:0]       bitIdx_q, bitIdx_d;
    logic [CNT_W-1:0] bitCnt_q, bitCnt_d;
    logic             armed_q;
    logic             bitEnd;

    assign bitEnd = (bitCnt_q == LAST_CNT);

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers. armed_q holds off the first fetch decision until
    // one full clock edge has passed after reset release, so the upstream
    // FIFO never sees a read on the first edge out of reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shift_q  <= 8'h00;
            bitIdx_q <= 3'd0;
            bitCnt_q <= '0;
            armed_q  <= 1'b0;
        end else begin
            shift_q  <= shift_d;
            bitIdx_q <= bitIdx_d;
            bitCnt_q <= bitCnt_d;
            armed_q  <= 1'b1;
        end
    end

    // Next-state and output decode. The bit counter defaults to zero so it
    // restarts on every state entry and at every bit boundary; it only
    // advances while a bit period is still running, so it can never wrap.
    // All outputs are decoded from registered state only.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bitIdx_d    = bitIdx_q;
        bitCnt_d    = '0;
        re_o        = 1'b0;
        tx_o        = 1'b1;
        busy_o      = 1'b1;
        byte_done_o = 1'b0;

        unique case (state_q)
            IDLE: begin
                busy_o = 1'b0;
                if (armed_q && en_i && !empty_i) begin
                    state_d = READ;
                end
            end

            READ: begin
                re_o    = 1'b1;
                state_d = LOAD;
            end

            LOAD: begin
                shift_d  = rdata_i;
                bitIdx_d = 3'd0;
                state_d  = START;
            end

            START: begin
                tx_o = 1'b0;
                if (bitEnd) begin
                    state_d = DATA;
                end else begin
                    bitCnt_d = bitCnt_q + CNT_W'(1);
                end
            end

            DATA: begin
                tx_o = shift_q[0];
                if (bitEnd) begin
                    shift_d  = {1'b0, shift_q[7:1]};
                    bitIdx_d = bitIdx_q + 3'd1;
                    if (bitIdx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    bitCnt_d = bitCnt_q + CNT_W'(1);
                end
            end

            STOP: begin
                if (bitEnd) begin
                    byte_done_o = 1'b1;
                    state_d     = IDLE;
                end else begin
                    bitCnt_d = bitCnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
